seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle arithmetic/logic unit driven directly by the control unit's DECODE/WAIT states. Captures opcode and operands on a `bgn` request, computes single-cycle ops in one clock and MUL/DIV/MOD with a 16-iteration sequential datapath, then raises `rdy` and holds results and flags until the next request. All outputs are registered.

## Interface
- `WIDTH`, 16, operand/result width; the iteration count equals `WIDTH`.
- `clk` in 1, system clock, rising edge.
- `rst` in 1, asynchronous, active-low reset.
- `bgn` in 1, operation request, level-sensitive, four-phase handshake with `rdy`.
- `opcode` in 6, instruction opcode; `[5:1]` selects the operation, `[0]` (immediate flag) is ignored.
- `A` in WIDTH, operand A.
- `B` in WIDTH, operand B (already muxed between register and immediate by the control unit).
- `acc1` out WIDTH, primary result.
- `acc2` out WIDTH, secondary result (MUL high half, DIV remainder, MOD quotient).
- `zero`, `negative`, `carry`, `overflow` out 1 each, status flags.
- `rdy` out 1, result valid.

## Operation
- States: IDLE, MULT, DIVD, DONE.
- IDLE, `bgn`=1 at an edge:
  - Latch `opcode`, `A` and `B` internally.
  - MUL goes to MULT.
  - DIV or MOD with B≠0 goes to DIVD.
  - Every other op computes, registers results and flags at that same edge, and goes to DONE.
- MULT: unsigned shift-add, one bit per cycle, 16 cycles. Result `{acc2,acc1}` = A*B. `carry`=0, `overflow`=|acc2.
- DIVD: restoring division, one quotient bit per cycle, 16 cycles.
  - DIV: `acc1`=quotient, `acc2`=remainder.
  - MOD: `acc1`=remainder, `acc2`=quotient.
  - `carry`=0, `overflow`=0.
- Divide by zero (DIV or MOD with B=0): single-cycle. `acc1`=FFFF, `acc2`=A, `overflow`=1, `carry`=0.
- DONE: `rdy`=1. Stays in DONE while `bgn`=1 (no restart). Returns to IDLE at the first edge with `bgn`=0.
- Operation codes, where op selects on `opcode[5:1]`:
  - ADD 00001: A+B. `carry`=bit 16. `overflow`=signed overflow.
  - SUB 00010: A−B. `carry`=borrow (A<B unsigned). `overflow`=signed overflow.
  - LSL 00100 / LSR 00011: logical shift of A by `B[3:0]`. `carry`=last bit shifted out, or 0 if the amount is 0.
  - RSL 00110 / RSR 00101: rotate A by `B[3:0]`. `carry`=last bit rotated across the end, or 0 if the amount is 0.
  - AND 01010, OR 01011, XOR 01100, NOT 01101 (~A): `carry`=0, `overflow`=0.
  - CMP 01110: flags from A−B as in SUB; `acc1`=A.
  - TST 01111: flags from A&B; `carry`=0, `overflow`=0; `acc1`=A.
  - INC 10000: A+1. `carry` when A=FFFF, `overflow` when A=7FFF.
  - DEC 10001: A−1. `carry` (borrow) when A=0000, `overflow` when A=8000.
  - MUL 00111, DIV 01000, MOD 01001: sequential, as described above.
  - Any other op: `acc1`, `acc2` and flags unchanged; completes in one cycle.
- Register writes per op:
  - `acc2` is written only by MUL, DIV and MOD; all other ops leave it unchanged.
  - `zero`=(value==0) and `negative`=value[15], where value is the computed result (for CMP/TST the A−B or A&B value, not `acc1`).
- Arithmetic is modulo 2^16 except MUL's 32-bit result.
- While in MULT or DIVD, changes on `bgn`, `opcode`, `A` or `B` are ignored.

## Timing
- Reset, asynchronous: state=IDLE, `acc1`=`acc2`=0, all flags 0, `rdy`=0, iteration counter 0.
- A reset asserted mid-operation aborts it; no partial result is ever visible.
- Single-cycle op: request sampled at edge k; results, flags and `rdy`=1 are valid after edge k.
- MUL/DIV/MOD: capture at edge k, iterations at edges k+1..k+16; results and `rdy`=1 are valid after edge k+16.
- `rdy` falls after the first edge in DONE at which `bgn`=0. If `bgn` was already low on entering DONE, `rdy` is a one-cycle pulse.
- No new request is accepted until back in IDLE: at least one cycle with `bgn`=0 between operations.
- Results and flags hold their values from the completing edge until the next completing edge.

## Test plan
- ADD A=7FFF, B=0001 → after 1 edge: `acc1`=8000, N=1, O=1, C=0, Z=0, `rdy`=1. Hold `bgn` high 5 cycles → `rdy` stays 1 and values are unchanged.
- SUB A=0003, B=0005 → `acc1`=FFFE, C=1, N=1, O=0. Then CMP A=0005, B=0005 → `acc1`=0005, Z=1, C=0.
- MUL A=1234, B=0100 → `rdy` rises exactly 16 edges after capture; `acc2`=0012, `acc1`=3400, O=1. Changing A/B and toggling `bgn` mid-operation has no effect.
- DIV A=0064, B=0007 → `acc1`=000E, `acc2`=0002. MOD with the same operands → `acc1`=0002, `acc2`=000E. DIV with B=0 → `acc1`=FFFF, `acc2`=0064, O=1, `rdy` after 1 edge.
- LSL A=8001, B=1 → `acc1`=0002, C=1. RSR A=0001, B=4 → `acc1`=1000. INC A=FFFF → `acc1`=0000, Z=1, C=1. NOP → `acc1`/flags unchanged, `rdy` after 1 edge.
- Assert `rst` low after 8 MUL iterations → `acc1`=`acc2`=0, flags 0, `rdy`=0 immediately. After release, ADD 0002+0003 → `acc1`=0005 with normal latency.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops finish at the capture edge; MUL/DIV/MOD take WIDTH more edges.
// Four-phase bgn/rdy handshake: results hold in DONE until bgn drops, inputs ignored while iterating.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bgn,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] acc1,
  output logic [WIDTH-1:0] acc2,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             rdy
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_LSR = 5'b00011;
  localparam logic [4:0] OP_LSL = 5'b00100;
  localparam logic [4:0] OP_RSR = 5'b00101;
  localparam logic [4:0] OP_RSL = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b00111;
  localparam logic [4:0] OP_DIV = 5'b01000;
  localparam logic [4:0] OP_MOD = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_XOR = 5'b01100;
  localparam logic [4:0] OP_NOT = 5'b01101;
  localparam logic [4:0] OP_CMP = 5'b01110;
  localparam logic [4:0] OP_TST = 5'b01111;
  localparam logic [4:0] OP_INC = 5'b10000;
  localparam logic [4:0] OP_DEC = 5'b10001;

  typedef enum logic [1:0] {IDLE, MULT, DIVD, DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wk_hi_q, wk_hi_d, wk_lo_q, wk_lo_d;
  logic [WIDTH-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
  logic             zero_q, zero_d, neg_q, neg_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;
  logic             rdy_q, rdy_d;

  logic             imm_unused;
  assign imm_unused = opcode[0];

  // Single-cycle datapath, evaluated straight from the request inputs.
  logic [4:0]       op_in;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   sum, diff, inc, dec, lsl, lsr;
  logic [WIDTH-1:0] rol, ror;
  logic [WIDTH-1:0] alu_res, alu_val;
  logic             alu_c, alu_o, alu_wr;

  always_comb begin
    op_in   = opcode[5:1];
    shamt   = B[SW-1:0];
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    inc     = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
    dec     = {1'b0, A} - {{WIDTH{1'b0}}, 1'b1};
    lsl     = {1'b0, A} << shamt;
    lsr     = {A, 1'b0} >> shamt;
    rol     = (A << shamt) | (A >> (WIDTH - int'(shamt)));
    ror     = (A >> shamt) | (A << (WIDTH - int'(shamt)));
    alu_res = acc1_q;
    alu_val = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_wr  = 1'b1;
    case (op_in)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_val = alu_res;
        alu_c   = sum[WIDTH];
        alu_o   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = (op_in == OP_CMP) ? A : diff[WIDTH-1:0];
        alu_val = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_o   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_LSL: begin
        alu_res = lsl[WIDTH-1:0];
        alu_val = alu_res;
        alu_c   = (shamt != '0) && lsl[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr[WIDTH:1];
        alu_val = alu_res;
        alu_c   = (shamt != '0) && lsr[0];
      end
      OP_RSL: begin
        alu_res = rol;
        alu_val = rol;
        alu_c   = (shamt != '0) && rol[0];
      end
      OP_RSR: begin
        alu_res = ror;
        alu_val = ror;
        alu_c   = (shamt != '0) && ror[WIDTH-1];
      end
      OP_AND: begin alu_res = A & B; alu_val = alu_res; end
      OP_OR:  begin alu_res = A | B; alu_val = alu_res; end
      OP_XOR: begin alu_res = A ^ B; alu_val = alu_res; end
      OP_NOT: begin alu_res = ~A;    alu_val = alu_res; end
      OP_TST: begin alu_res = A;     alu_val = A & B;   end
      OP_INC: begin
        alu_res = inc[WIDTH-1:0];
        alu_val = alu_res;
        alu_c   = inc[WIDTH];
        alu_o   = !A[WIDTH-1] && alu_res[WIDTH-1];
      end
      OP_DEC: begin
        alu_res = dec[WIDTH-1:0];
        alu_val = alu_res;
        alu_c   = dec[WIDTH];
        alu_o   = A[WIDTH-1] && !alu_res[WIDTH-1];
      end
      default: alu_wr = 1'b0;
    endcase
  end

  // Iterative datapath: wk_hi/wk_lo are product halves (MUL) or remainder/quotient (DIV).
  logic [WIDTH:0]   mul_add, r_sh, trial;
  logic [WIDTH-1:0] rem_n, quot_n;
  logic             last;

  always_comb begin
    mul_add = {1'b0, wk_hi_q} + ({1'b0, a_q} & {(WIDTH+1){wk_lo_q[0]}});
    r_sh    = {wk_hi_q, wk_lo_q[WIDTH-1]};
    trial   = r_sh - {1'b0, b_q};
    rem_n   = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_n  = {wk_lo_q[WIDTH-2:0], !trial[WIDTH]};
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    wk_hi_d = wk_hi_q;
    wk_lo_d = wk_lo_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bgn) begin
          op_d    = op_in;
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          state_d = DONE;
          if (op_in == OP_MUL) begin
            wk_hi_d = '0;
            wk_lo_d = B;
            state_d = MULT;
          end else if (op_in == OP_DIV || op_in == OP_MOD) begin
            if (B != '0) begin
              wk_hi_d = '0;
              wk_lo_d = A;
              state_d = DIVD;
            end else begin
              acc1_d  = '1;
              acc2_d  = A;
              zero_d  = 1'b0;
              neg_d   = 1'b1;
              carry_d = 1'b0;
              ovf_d   = 1'b1;
            end
          end else if (alu_wr) begin
            acc1_d  = alu_res;
            zero_d  = (alu_val == '0);
            neg_d   = alu_val[WIDTH-1];
            carry_d = alu_c;
            ovf_d   = alu_o;
          end
        end
      end
      MULT: begin
        wk_hi_d = mul_add[WIDTH:1];
        wk_lo_d = {mul_add[0], wk_lo_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          acc2_d  = mul_add[WIDTH:1];
          acc1_d  = wk_lo_d;
          zero_d  = (wk_lo_d == '0);
          neg_d   = wk_lo_d[WIDTH-1];
          carry_d = 1'b0;
          ovf_d   = |mul_add[WIDTH:1];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DIVD: begin
        wk_hi_d = rem_n;
        wk_lo_d = quot_n;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          acc1_d  = (op_q == OP_DIV) ? quot_n : rem_n;
          acc2_d  = (op_q == OP_DIV) ? rem_n : quot_n;
          zero_d  = (acc1_d == '0);
          neg_d   = acc1_d[WIDTH-1];
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bgn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      wk_hi_q <= '0;
      wk_lo_q <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      wk_hi_q <= wk_hi_d;
      wk_lo_q <= wk_lo_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

  assign acc1     = acc1_q;
  assign acc2     = acc2_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign rdy      = rdy_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: each task drives one scenario and checks against hand-computed values.
module tb_seq_alu;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_LSL = 5'b00100;
  localparam logic [4:0] OP_RSR = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00111;
  localparam logic [4:0] OP_DIV = 5'b01000;
  localparam logic [4:0] OP_MOD = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01110;
  localparam logic [4:0] OP_INC = 5'b10000;
  localparam logic [4:0] OP_DEC = 5'b10001;
  localparam logic [4:0] OP_NOP = 5'b11111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bgn = 1'b0;
  logic [5:0]  opcode = '0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] acc1, acc2;
  logic        zero, negative, carry, overflow, rdy;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign flags = {zero, negative, carry, overflow};

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bgn(bgn), .opcode(opcode), .A(A), .B(B),
    .acc1(acc1), .acc2(acc2), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow), .rdy(rdy)
  );

  // Raise a request at the negedge; return 1ns after the capturing edge.
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bgn = 1'b1;
    opcode = {op, a[0]};
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_bgn();
    @(negedge clk);
    bgn = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(output int edges);
    edges = 0;
    while (rdy !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({acc1, acc2, flags, rdy} !== 37'd0) begin
      fails++;
      $display("FAIL reset_state: acc1=%h acc2=%h flags=%b rdy=%b, required all zero", acc1, acc2, flags, rdy);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add_hold();
    issue(OP_ADD, 16'h7FFF, 16'h0001);
    tests++;
    if (acc1 !== 16'h8000 || flags !== 4'b0101 || rdy !== 1'b1) begin
      fails++;
      $display("FAIL add_ovf: acc1=%h flags=%b rdy=%b, required 8000 0101 1", acc1, flags, rdy);
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (acc1 !== 16'h8000 || flags !== 4'b0101 || rdy !== 1'b1) begin
      fails++;
      $display("FAIL add_hold: acc1=%h flags=%b rdy=%b, required 8000 0101 1", acc1, flags, rdy);
    end
    drop_bgn();
    tests++;
    if (rdy !== 1'b0 || acc1 !== 16'h8000) begin
      fails++;
      $display("FAIL add_release: rdy=%b acc1=%h, required 0 8000", rdy, acc1);
    end
  endtask

  task automatic test_sub_cmp();
    issue(OP_SUB, 16'h0003, 16'h0005);
    tests++;
    if (acc1 !== 16'hFFFE || flags !== 4'b0110 || rdy !== 1'b1) begin
      fails++;
      $display("FAIL sub_borrow: acc1=%h flags=%b rdy=%b, required FFFE 0110 1", acc1, flags, rdy);
    end
    drop_bgn();
    issue(OP_CMP, 16'h0005, 16'h0005);
    tests++;
    if (acc1 !== 16'h0005 || flags !== 4'b1000 || acc2 !== 16'h0000) begin
      fails++;
      $display("FAIL cmp_equal: acc1=%h flags=%b acc2=%h, required 0005 1000 0000", acc1, flags, acc2);
    end
    drop_bgn();
  endtask

  task automatic test_mul();
    int rise;
    int mid_acc1_ok;
    rise = 0;
    mid_acc1_ok = 1;
    issue(OP_MUL, 16'h1234, 16'h0100);
    for (int i = 1; i <= 24 && rise == 0; i++) begin
      @(negedge clk);
      if (i <= 15) begin
        bgn = i[0];
        A = 16'hFFFF;
        B = 16'hFFFF;
        opcode = {OP_ADD, 1'b0};
      end else begin
        bgn = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == 8 && acc1 !== 16'h0005) mid_acc1_ok = 0;
      if (rdy === 1'b1) rise = i;
    end
    tests++;
    if (rise != 16) begin
      fails++;
      $display("FAIL mul_latency: rdy after %0d edges, required 16", rise);
    end
    tests++;
    if (mid_acc1_ok != 1) begin
      fails++;
      $display("FAIL mul_no_partial: acc1 changed mid-operation, required 0005");
    end
    tests++;
    if (acc2 !== 16'h0012 || acc1 !== 16'h3400 || overflow !== 1'b1 || carry !== 1'b0) begin
      fails++;
      $display("FAIL mul_result: acc2=%h acc1=%h O=%b C=%b, required 0012 3400 1 0", acc2, acc1, overflow, carry);
    end
    drop_bgn();
  endtask

  task automatic test_div_mod();
    int edges;
    issue(OP_DIV, 16'h0064, 16'h0007);
    wait_rdy(edges);
    tests++;
    if (edges != 16 || acc1 !== 16'h000E || acc2 !== 16'h0002 || {carry, overflow} !== 2'b00) begin
      fails++;
      $display("FAIL div: edges=%0d acc1=%h acc2=%h CO=%b, required 16 000E 0002 00", edges, acc1, acc2, {carry, overflow});
    end
    drop_bgn();
    issue(OP_MOD, 16'h0064, 16'h0007);
    wait_rdy(edges);
    tests++;
    if (edges != 16 || acc1 !== 16'h0002 || acc2 !== 16'h000E) begin
      fails++;
      $display("FAIL mod: edges=%0d acc1=%h acc2=%h, required 16 0002 000E", edges, acc1, acc2);
    end
    drop_bgn();
    issue(OP_DIV, 16'h0064, 16'h0000);
    tests++;
    if (rdy !== 1'b1 || acc1 !== 16'hFFFF || acc2 !== 16'h0064 || overflow !== 1'b1 || carry !== 1'b0) begin
      fails++;
      $display("FAIL div_zero: rdy=%b acc1=%h acc2=%h O=%b C=%b, required 1 FFFF 0064 1 0", rdy, acc1, acc2, overflow, carry);
    end
    drop_bgn();
  endtask

  task automatic test_shift_inc_nop();
    issue(OP_LSL, 16'h8001, 16'h0001);
    tests++;
    if (acc1 !== 16'h0002 || flags !== 4'b0010) begin
      fails++;
      $display("FAIL lsl: acc1=%h flags=%b, required 0002 0010", acc1, flags);
    end
    drop_bgn();
    issue(OP_RSR, 16'h0001, 16'h0004);
    tests++;
    if (acc1 !== 16'h1000 || carry !== 1'b0) begin
      fails++;
      $display("FAIL rsr: acc1=%h C=%b, required 1000 0", acc1, carry);
    end
    drop_bgn();
    issue(OP_INC, 16'hFFFF, 16'h0000);
    tests++;
    if (acc1 !== 16'h0000 || flags !== 4'b1010 || acc2 !== 16'h0064) begin
      fails++;
      $display("FAIL inc_wrap: acc1=%h flags=%b acc2=%h, required 0000 1010 0064", acc1, flags, acc2);
    end
    drop_bgn();
    issue(OP_DEC, 16'h8000, 16'h0000);
    tests++;
    if (acc1 !== 16'h7FFF || flags !== 4'b0001) begin
      fails++;
      $display("FAIL dec_ovf: acc1=%h flags=%b, required 7FFF 0001", acc1, flags);
    end
    drop_bgn();
    issue(OP_NOP, 16'h1111, 16'h2222);
    tests++;
    if (rdy !== 1'b1 || acc1 !== 16'h7FFF || flags !== 4'b0001 || acc2 !== 16'h0064) begin
      fails++;
      $display("FAIL nop: rdy=%b acc1=%h flags=%b acc2=%h, required 1 7FFF 0001 0064", rdy, acc1, flags, acc2);
    end
    drop_bgn();
  endtask

  task automatic test_reset_mid_mul();
    issue(OP_MUL, 16'h1234, 16'h0100);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({acc1, acc2, flags, rdy} !== 37'd0) begin
      fails++;
      $display("FAIL reset_mid_mul: acc1=%h acc2=%h flags=%b rdy=%b, required all zero", acc1, acc2, flags, rdy);
    end
    @(negedge clk);
    bgn = 1'b0;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (rdy !== 1'b0 || acc1 !== 16'h0000 || acc2 !== 16'h0000) begin
      fails++;
      $display("FAIL reset_abort: rdy=%b acc1=%h acc2=%h, required 0 0000 0000", rdy, acc1, acc2);
    end
    issue(OP_ADD, 16'h0002, 16'h0003);
    tests++;
    if (rdy !== 1'b1 || acc1 !== 16'h0005 || flags !== 4'b0000) begin
      fails++;
      $display("FAIL add_after_reset: rdy=%b acc1=%h flags=%b, required 1 0005 0000", rdy, acc1, flags);
    end
    drop_bgn();
  endtask

  initial begin
    test_reset();
    test_add_hold();
    test_sub_cmp();
    test_mul();
    test_div_mod();
    test_shift_inc_nop();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
